// File: rtl/ovr_mac_scheduler.sv
// One-vs-rest logistic-regression scorer: a single time-multiplexed MAC walks
// every class's 81-term inner product and keeps the running arg-max.
module ovr_mac_scheduler #(
    parameter int NUM_CLASS = 10,
    parameter int NUM_FEAT  = 81,
    parameter int PIX_W     = 7,
    parameter int ACC_W     = 32,
    parameter int CLS_W     = 4,
    parameter int TADDR_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [6:0]         pix_addr,
    input  logic [PIX_W-1:0]   pix_data,
    output logic [TADDR_W-1:0] theta_addr,
    input  logic [ACC_W-1:0]   theta_data,
    output logic               busy,
    output logic               done,
    output logic [CLS_W-1:0]   class_id,
    output logic [ACC_W-1:0]   score
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CMP,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CLS_W-1:0]   cls;
    logic [6:0]         idx;
    logic [ACC_W-1:0]   acc;
    logic               rd_vld;
    logic [6:0]         rd_idx;
    logic [ACC_W-1:0]   best_score;
    logic [CLS_W-1:0]   best_cls;

    logic               last_idx;
    logic               last_cls;
    logic [TADDR_W-1:0] cls_base;
    logic [ACC_W-1:0]   ext_pix;
    logic [ACC_W-1:0]   term;
    logic               take_new;
    logic [ACC_W-1:0]   nb_score;
    logic [CLS_W-1:0]   nb_cls;

    assign last_idx = (idx == 7'(NUM_FEAT - 1));
    assign last_cls = (cls == CLS_W'(NUM_CLASS - 1));
    assign cls_base = TADDR_W'(cls) * TADDR_W'(NUM_FEAT);

    // Truncated product of zero-extended pixel and theta equals the signed
    // product modulo 2^ACC_W, so a plain ACC_W-wide multiply is sufficient.
    always_comb begin
        ext_pix = {{(ACC_W - PIX_W){1'b0}}, pix_data};
        if (rd_idx == '0) begin
            term = theta_data << 16;
        end else begin
            term = ext_pix * theta_data;
        end
    end

    always_comb begin
        take_new = (cls == '0) || ($signed(acc) > $signed(best_score));
        nb_score = take_new ? acc : best_score;
        nb_cls   = take_new ? cls : best_cls;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        pix_addr   = '0;
        theta_addr = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                pix_addr   = idx;
                theta_addr = cls_base + TADDR_W'(idx);
                if (last_idx) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = CMP;
            end
            CMP: begin
                busy      = 1'b1;
                state_nxt = last_cls ? DONE : RUN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cls        <= '0;
            idx        <= '0;
            acc        <= '0;
            rd_vld     <= 1'b0;
            rd_idx     <= '0;
            best_score <= '0;
            best_cls   <= '0;
            class_id   <= '0;
            score      <= '0;
        end else begin
            rd_vld <= (state == RUN);
            rd_idx <= idx;

            if (rd_vld) begin
                acc <= acc + term;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        cls <= '0;
                        idx <= '0;
                        acc <= '0;
                    end
                end
                RUN: begin
                    idx <= idx + 7'd1;
                end
                CMP: begin
                    // The final result is captured here so it is already
                    // visible during the done cycle.
                    best_score <= nb_score;
                    best_cls   <= nb_cls;
                    if (last_cls) begin
                        class_id <= nb_cls;
                        score    <= nb_score;
                    end else begin
                        cls <= cls + CLS_W'(1);
                        idx <= '0;
                        acc <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ovr_mac_scheduler.sv
// Directed bench for ovr_mac_scheduler: weight/pixel patterns with
// hand-computed winners, cycle-exact address/busy/done timing and reset abort.
module tb_ovr_mac_scheduler;

    localparam int NC = 10;
    localparam int NF = 81;
    localparam int PW = 7;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam int TW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [6:0]    pix_addr;
    logic [PW-1:0] pix_data;
    logic [TW-1:0] theta_addr;
    logic [AW-1:0] theta_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] class_id;
    logic [AW-1:0] score;

    logic [PW-1:0] pix_mem   [NF];
    logic [AW-1:0] theta_mem [NC*NF];

    int n_cmp = 0;
    int n_bad = 0;

    ovr_mac_scheduler #(
        .NUM_CLASS (NC),
        .NUM_FEAT  (NF),
        .PIX_W     (PW),
        .ACC_W     (AW),
        .CLS_W     (CW),
        .TADDR_W   (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .theta_addr (theta_addr),
        .theta_data (theta_data),
        .busy       (busy),
        .done       (done),
        .class_id   (class_id),
        .score      (score)
    );

    always #5 clk = ~clk;

    // Window and ROM both answer one cycle after the address.
    always @(posedge clk) begin
        pix_data   <= (int'(pix_addr) < NF) ? pix_mem[pix_addr] : '0;
        theta_data <= (int'(theta_addr) < NC*NF) ? theta_mem[theta_addr] : '0;
    end

    typedef struct {
        int          pat;
        bit          repulse;
        logic [3:0]  exp_cls;
        logic [31:0] exp_score;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < NF; i++) pix_mem[i] = '0;
        for (int i = 0; i < NC*NF; i++) theta_mem[i] = '0;
        case (pat)
            0: begin
                for (int c = 0; c < NC; c++) theta_mem[c*NF] = 32'(c - 5);
            end
            1: begin
                for (int i = 0; i < NF; i++) pix_mem[i] = 7'd127;
                for (int i = 1; i < NF; i++) theta_mem[3*NF+i] = 32'd1;
            end
            2: begin
                for (int i = 0; i < NF; i++) pix_mem[i] = 7'(i);
                theta_mem[2*NF] = 32'd1;
                theta_mem[7*NF] = 32'd1;
                for (int i = 1; i < NF; i++) begin
                    theta_mem[2*NF+i] = 32'd2;
                    theta_mem[7*NF+i] = 32'd2;
                end
            end
            default: begin
                pix_mem[1]   = 7'd127;
                theta_mem[0] = 32'h0000_7FFF;
                theta_mem[1] = 32'h7FFF_FFFF;
                for (int c = 1; c < NC; c++) theta_mem[c*NF] = 32'hFFFF_FFFE;
            end
        endcase
    endtask

    // 32-bit wrapping reference scorer with lower-index tie break.
    task automatic ref_model(output logic [3:0] mc, output logic [31:0] ms);
        logic [31:0] a;
        mc = '0;
        ms = '0;
        for (int c = 0; c < NC; c++) begin
            a = theta_mem[c*NF] << 16;
            for (int i = 1; i < NF; i++) a = a + {25'd0, pix_mem[i]} * theta_mem[c*NF+i];
            if (c == 0 || $signed(a) > $signed(ms)) begin
                ms = a;
                mc = 4'(c);
            end
        end
    endtask

    // Entered #1 after an edge with the DUT idle; start is raised in this cycle.
    task automatic run_frame(input bit repulse, output int done_cyc,
                             output int addr_err, output int busy_err);
        int cyc;
        int ph;
        logic [6:0]  ep;
        logic [9:0]  et;
        done_cyc = -1;
        addr_err = 0;
        busy_err = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc <= 1000) begin
            ph = (cyc - 1) % 83;
            if (cyc <= 830 && ph < 81) begin
                ep = 7'(ph);
                et = 10'(((cyc - 1) / 83) * NF + ph);
            end else begin
                ep = '0;
                et = '0;
            end
            if (pix_addr !== ep || theta_addr !== et) addr_err++;
            if (busy !== (cyc <= 830)) busy_err++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            start = repulse && (cyc == 5 || cyc == 400);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        int dc, ae, be;
        int cyc;
        logic [3:0]  mc;
        logic [31:0] ms;

        vecs[0] = '{pat: 3, repulse: 1'b0, exp_cls: 4'd0, exp_score: 32'hFFFE_FF81};
        vecs[1] = '{pat: 1, repulse: 1'b0, exp_cls: 4'd3, exp_score: 32'd10160};
        vecs[2] = '{pat: 2, repulse: 1'b0, exp_cls: 4'd2, exp_score: 32'd72016};
        vecs[3] = '{pat: 0, repulse: 1'b1, exp_cls: 4'd9, exp_score: 32'd262144};

        rst   = 1'b1;
        start = 1'b0;
        load_pattern(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy",       32'(busy),       32'd0);
        chk("reset_done",       32'(done),       32'd0);
        chk("reset_class_id",   32'(class_id),   32'd0);
        chk("reset_score",      score,           32'd0);
        chk("reset_pix_addr",   32'(pix_addr),   32'd0);
        chk("reset_theta_addr", 32'(theta_addr), 32'd0);
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            load_pattern(vecs[v].pat);
            ref_model(mc, ms);
            run_frame(vecs[v].repulse, dc, ae, be);
            chk($sformatf("p%0d_done_cycle", vecs[v].pat), 32'(dc), 32'd831);
            chk($sformatf("p%0d_class_id", vecs[v].pat), 32'(class_id), 32'(vecs[v].exp_cls));
            chk($sformatf("p%0d_score", vecs[v].pat), score, vecs[v].exp_score);
            chk($sformatf("p%0d_model_class", vecs[v].pat), 32'(class_id), 32'(mc));
            chk($sformatf("p%0d_model_score", vecs[v].pat), score, ms);
            chk($sformatf("p%0d_addr_seq_errors", vecs[v].pat), 32'(ae), 32'd0);
            chk($sformatf("p%0d_busy_errors", vecs[v].pat), 32'(be), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("p%0d_done_pulse_width", vecs[v].pat), 32'(done), 32'd0);
            chk($sformatf("p%0d_idle_busy", vecs[v].pat), 32'(busy), 32'd0);
            chk($sformatf("p%0d_class_hold", vecs[v].pat), 32'(class_id), 32'(vecs[v].exp_cls));
            chk($sformatf("p%0d_score_hold", vecs[v].pat), score, vecs[v].exp_score);
        end

        // Mid-frame reset: abort at cycle 300, then a fresh frame from scratch.
        load_pattern(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midrun_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_abort_busy",       32'(busy),       32'd0);
        chk("rst_abort_done",       32'(done),       32'd0);
        chk("rst_abort_class_id",   32'(class_id),   32'd0);
        chk("rst_abort_score",      score,           32'd0);
        chk("rst_abort_theta_addr", 32'(theta_addr), 32'd0);
        run_frame(1'b0, dc, ae, be);
        chk("after_rst_done_cycle", 32'(dc),       32'd831);
        chk("after_rst_class_id",   32'(class_id), 32'd3);
        chk("after_rst_score",      score,         32'd10160);
        chk("after_rst_addr_seq",   32'(ae),       32'd0);
        chk("after_rst_busy",       32'(be),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
